// File: rtl/counter_pkg.sv
// Shared counter definitions: default width and FSM state encodings used by
// the up-counters and the countdown timer in this clock domain.
package counter_pkg;

  localparam int CNT_W = 7;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/countdown_7bit_timer.sv
// Loadable down-counter/timer with one-shot and auto-reload modes; flags
// terminal count with a registered one-cycle tc pulse.
module countdown_7bit_timer
  import counter_pkg::*;
#(
  parameter int N = CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [N-1:0] load_value,
  input  logic         count_enb,
  input  logic         auto_reload,
  output logic [N-1:0] count,
  output logic         tc,
  output logic         busy,
  output logic         done
);

  state_t       state, state_nx;
  logic [N-1:0] reload_reg, reload_nx, count_nx;
  logic         tc_nx;

  always_comb begin
    state_nx  = state;
    count_nx  = count;
    reload_nx = reload_reg;
    tc_nx     = 1'b0;
    if (load) begin
      count_nx  = load_value;
      reload_nx = load_value;
      state_nx  = (load_value != '0) ? S_RUN : S_DONE;
    end else if (state == S_RUN && count_enb) begin
      if (count == N'(1)) begin
        tc_nx = 1'b1;
        if (auto_reload) begin
          count_nx = reload_reg;
        end else begin
          count_nx = '0;
          state_nx = S_DONE;
        end
      end else if (count != '0) begin
        // count is never 0 in RUN; the guard keeps the decrement underflow-free
        count_nx = count - N'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      count      <= '0;
      reload_reg <= '0;
      tc         <= 1'b0;
    end else begin
      state      <= state_nx;
      count      <= count_nx;
      reload_reg <= reload_nx;
      tc         <= tc_nx;
    end
  end

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_countdown_7bit_timer.sv
// Scoreboard bench: the driver pushes the expected post-edge outputs from a
// behavioural model; a monitor pops and compares after every clock edge.
module tb_countdown_7bit_timer;

  logic       clk = 1'b0;
  logic       reset = 1'b0, load = 1'b0, count_enb = 1'b0, auto_reload = 1'b0;
  logic [6:0] load_value = '0;
  logic [6:0] count;
  logic       tc, busy, done;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int c;
    bit tc;
    bit busy;
    bit done;
  } exp_t;

  exp_t q[$];

  // model: mode 0=idle 1=running 2=finished
  int  m_mode = 0;
  int  m_cnt  = 0;
  int  m_start = 0;
  bit  m_tc   = 0;

  countdown_7bit_timer #(.N(7)) dut (
    .clk(clk), .reset(reset), .load(load), .load_value(load_value),
    .count_enb(count_enb), .auto_reload(auto_reload),
    .count(count), .tc(tc), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic void model_edge(bit rst, bit ld, int lv, bit en, bit ar);
    m_tc = 0;
    if (rst) begin
      m_mode = 0; m_cnt = 0; m_start = 0;
    end else if (ld) begin
      m_cnt = lv; m_start = lv;
      m_mode = (lv == 0) ? 2 : 1;
    end else if (m_mode == 1 && en) begin
      if (m_cnt == 1) begin
        m_tc = 1;
        if (ar) m_cnt = m_start;
        else begin m_cnt = 0; m_mode = 2; end
      end else begin
        m_cnt = m_cnt - 1;
      end
    end
  endfunction

  // drive one cycle from a negedge; returns at the following negedge
  task automatic step(input bit rst, input bit ld, input int lv, input bit en, input bit ar);
    exp_t e;
    reset = rst; load = ld; load_value = 7'(lv); count_enb = en; auto_reload = ar;
    model_edge(rst, ld, lv, en, ar);
    e.c = m_cnt; e.tc = m_tc; e.busy = (m_mode == 1); e.done = (m_mode == 2);
    q.push_back(e);
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("count", int'(count), e.c);
      check("tc",    int'(tc),    int'(e.tc));
      check("busy",  int'(busy),  int'(e.busy));
      check("done",  int'(done),  int'(e.done));
    end
  end

  initial begin
    int n;
    int tc_seen;
    @(negedge clk);
    // reset, then reset mid-RUN for two cycles
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 1, 5, 1, 0);
    step(0, 0, 0, 1, 0);
    step(1, 0, 0, 1, 0);
    step(1, 0, 0, 1, 0);
    check("reset_count", int'(count), 0);
    check("reset_busy",  int'(busy),  0);
    step(0, 0, 0, 0, 0);
    // one-shot
    step(0, 1, 5, 1, 0);
    repeat (8) step(0, 0, 0, 1, 0);
    check("oneshot_done", int'(done), 1);
    // auto-reload
    step(0, 1, 3, 1, 1);
    tc_seen = 0;
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 0, 1, 1);
      if (tc) tc_seen++;
    end
    check("reload_tc_pulses", tc_seen, 4);
    // enable gaps
    step(0, 1, 4, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, (i % 2 == 0), 0);
    // collisions: reload while count==1, then load zero
    step(0, 1, 3, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 1, 9, 1, 0);
    check("collide_count", int'(count), 9);
    step(0, 1, 0, 1, 0);
    check("load0_done", int'(done), 1);
    repeat (3) step(0, 0, 0, 1, 1);
    // max load: tc observed exactly 127 edges after the load edge
    step(0, 1, 127, 1, 0);
    n = 0;
    do begin
      step(0, 0, 0, 1, 0);
      n++;
    end while (!tc && n < 200);
    check("tc_latency_127", n, 127);
    repeat (4) step(0, 0, 0, 1, 0);
    // idle ignores enable
    step(1, 0, 0, 0, 0);
    repeat (3) step(0, 0, 0, 1, 0);
    // random
    for (int i = 0; i < 3000; i++) begin
      bit rst, ld, en, ar;
      int lv;
      rst = ($urandom_range(199) == 0);
      ld  = ($urandom_range(15) == 0);
      lv  = ($urandom_range(3) == 0) ? $urandom_range(127) : $urandom_range(6);
      en  = ($urandom_range(3) != 0);
      ar  = $urandom_range(1);
      step(rst, ld, lv, en, ar);
    end
    n = 0;
    while (q.size() > 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
